// File: rtl/ex_md_stage.sv
// rtl/ex_md_stage.sv - execute stage: RV ALU, iterative radix-2 mul/div, N-source forwarding
// Result is registered into the EX/MEM boundary; oBusy holds ID/EX while mul/div iterates.
module ex_md_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic                 iClk,
  input  logic                 nRst,
  input  logic                 iStall,
  input  logic                 iFlush,
  input  logic                 iValid,
  input  logic                 iExEn,
  input  logic                 iImmEn,
  input  logic [2:0]           iFunc3,
  input  logic [6:0]           iFunc7,
  input  logic [XLEN-1:0]      iRs1,
  input  logic [XLEN-1:0]      iRs2,
  input  logic [XLEN-1:0]      iImm,
  input  logic [4:0]           iRdAddr,
  input  logic [NFWD-1:0]      iFwS1,
  input  logic [NFWD-1:0]      iFwS2,
  input  logic [NFWD*XLEN-1:0] iFwData,
  output logic                 oValid,
  output logic [4:0]           oRdAddr,
  output logic [XLEN-1:0]      oRdValue,
  output logic [XLEN-1:0]      oStoreData,
  output logic                 oBusy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] CNT_INIT = SW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   cnt;
  logic [XLEN-1:0] ma, mb, hi, lo;
  logic            sa, sb;
  logic [2:0]      f3;
  logic [4:0]      rd;

  logic [XLEN-1:0] fw1, fw2, op_b, alu;
  logic [SW-1:0]   shamt;
  logic            is_md, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;

  // Lowest index wins, so walk from the top and let lower indices overwrite.
  always_comb begin
    fw1 = iRs1;
    fw2 = iRs2;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (iFwS1[i]) fw1 = iFwData[i*XLEN +: XLEN];
      if (iFwS2[i]) fw2 = iFwData[i*XLEN +: XLEN];
    end
  end

  assign op_b  = iImmEn ? iImm : fw2;
  assign shamt = op_b[SW-1:0];
  assign is_md = iValid & iExEn & ~iImmEn & (iFunc7 == 7'b0000001);

  always_comb begin
    alu = fw1 + op_b;
    if (iValid && iExEn) begin
      case (iFunc3)
        3'd0: alu = (iFunc7[5] && !iImmEn) ? fw1 - op_b : fw1 + op_b;
        3'd1: alu = fw1 << shamt;
        3'd2: alu = {{(XLEN-1){1'b0}}, $signed(fw1) < $signed(op_b)};
        3'd3: alu = {{(XLEN-1){1'b0}}, fw1 < op_b};
        3'd4: alu = fw1 ^ op_b;
        3'd5: alu = iFunc7[5] ? XLEN'($signed(fw1) >>> shamt) : fw1 >> shamt;
        3'd6: alu = fw1 | op_b;
        3'd7: alu = fw1 & op_b;
        default: alu = fw1 + op_b;
      endcase
    end
  end

  // MUL/MULH: both signed, MULHSU: rs1 only, MULHU: neither; DIV/REM signed, DIVU/REMU not.
  assign a_signed = iFunc3[2] ? ~iFunc3[0] : (iFunc3[1:0] != 2'b11);
  assign b_signed = iFunc3[2] ? ~iFunc3[0] : ~iFunc3[1];
  assign neg_a    = a_signed & fw1[XLEN-1];
  assign neg_b    = b_signed & fw2[XLEN-1];
  assign abs_a    = neg_a ? -fw1 : fw1;
  assign abs_b    = neg_b ? -fw2 : fw2;

  logic [XLEN:0]   mul_sum, shifted, diff;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, mb};
    if (!f3[2]) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_n = diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_n = shifted[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b0};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, md_res;

  always_comb begin
    prod_s = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    quo    = (sa ^ sb) ? -lo : lo;
    rem    = sa ? -hi : hi;
    if (mb == '0) begin
      quo = '1;
      rem = sa ? -ma : ma;
    end else if (sa && sb && ma == MIN_VAL && mb == XLEN'(1)) begin
      quo = MIN_VAL;
      rem = '0;
    end
    if (f3[2])          md_res = f3[1] ? rem : quo;
    else if (f3 == 3'd0) md_res = prod_s[XLEN-1:0];
    else                md_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      hi <= '0;
      lo <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      f3 <= '0;
      rd <= '0;
      oValid <= 1'b0;
      oRdAddr <= '0;
      oRdValue <= '0;
      oStoreData <= '0;
      oBusy <= 1'b0;
    end else if (iFlush) begin
      state <= IDLE;
      oBusy <= 1'b0;
      oValid <= 1'b0;
      oRdAddr <= '0;
      oRdValue <= '0;
      oStoreData <= '0;
    end else begin
      case (state)
        IDLE: if (!iStall) begin
          if (is_md) begin
            ma <= abs_a;
            mb <= abs_b;
            sa <= neg_a;
            sb <= neg_b;
            f3 <= iFunc3;
            rd <= iRdAddr;
            hi <= '0;
            lo <= iFunc3[2] ? abs_a : abs_b;
            cnt <= CNT_INIT;
            oValid <= 1'b0;
            oBusy <= 1'b1;
            state <= RUN;
          end else begin
            oValid <= iValid;
            oRdAddr <= iRdAddr;
            oRdValue <= alu;
            oStoreData <= fw2;
          end
        end
        RUN: begin
          hi <= hi_n;
          lo <= lo_n;
          if (cnt == '0) state <= DONE;
          else cnt <= cnt - 1'b1;
        end
        DONE: if (!iStall) begin
          oValid <= 1'b1;
          oRdAddr <= rd;
          oRdValue <= md_res;
          oStoreData <= '0;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_md_stage.sv
// tb/tb_ex_md_stage.sv - directed self-checking bench for ex_md_stage (XLEN=32, NFWD=2)
module tb_ex_md_stage;

  logic        iClk, nRst, iStall, iFlush, iValid, iExEn, iImmEn;
  logic [2:0]  iFunc3;
  logic [6:0]  iFunc7;
  logic [31:0] iRs1, iRs2, iImm;
  logic [4:0]  iRdAddr;
  logic [1:0]  iFwS1, iFwS2;
  logic [63:0] iFwData;
  logic        oValid, oBusy;
  logic [4:0]  oRdAddr;
  logic [31:0] oRdValue, oStoreData;

  int checks = 0;
  int errors = 0;

  ex_md_stage #(.XLEN(32), .NFWD(2)) dut (
    .iClk(iClk), .nRst(nRst), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iExEn(iExEn), .iImmEn(iImmEn), .iFunc3(iFunc3), .iFunc7(iFunc7),
    .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm), .iRdAddr(iRdAddr),
    .iFwS1(iFwS1), .iFwS2(iFwS2), .iFwData(iFwData),
    .oValid(oValid), .oRdAddr(oRdAddr), .oRdValue(oRdValue),
    .oStoreData(oStoreData), .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_op(input logic valid, input logic immen, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd);
    iValid = valid;
    iExEn = 1'b1;
    iImmEn = immen;
    iFunc3 = f3;
    iFunc7 = f7;
    iRs1 = rs1;
    iRs2 = rs2;
    iImm = imm;
    iRdAddr = rd;
  endtask

  // Issue one mul/div, then count cycles with oBusy high and check the result when it drops.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    set_op(1'b1, 1'b0, f3, 7'h01, a, b, 32'h0, 5'd10);
    tick();
    iValid = 1'b0;
    n = 0;
    while (oBusy && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_busy"}, n, 33);
    check({tag, "_valid"}, {31'b0, oValid}, 32'h1);
    check({tag, "_rd"}, {27'b0, oRdAddr}, 32'd10);
    check(tag, oRdValue, exp);
  endtask

  initial begin
    nRst = 1'b0; iStall = 1'b0; iFlush = 1'b0;
    iFwS1 = 2'b00; iFwS2 = 2'b00; iFwData = 64'h0;
    set_op(1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    #3;
    check("rst_valid", {31'b0, oValid}, 32'h0);
    check("rst_rd", {27'b0, oRdAddr}, 32'h0);
    check("rst_value", oRdValue, 32'h0);
    check("rst_store", oStoreData, 32'h0);
    check("rst_busy", {31'b0, oBusy}, 32'h0);
    #9 nRst = 1'b1;
    tick();

    set_op(1'b1, 1'b1, 3'd0, 7'h00, 32'h7FFFFFFF, 32'h0, 32'h1, 5'd5);
    tick();
    check("addi_valid", {31'b0, oValid}, 32'h1);
    check("addi_rd", {27'b0, oRdAddr}, 32'd5);
    check("addi", oRdValue, 32'h80000000);

    set_op(1'b1, 1'b1, 3'd5, 7'h20, 32'h80000000, 32'h0, 32'h00000404, 5'd6);
    tick();
    check("srai", oRdValue, 32'hF8000000);

    set_op(1'b1, 1'b0, 3'd0, 7'h00, 32'h00000009, 32'h00000002, 32'h0, 5'd7);
    iFunc7 = 7'h20;
    tick();
    check("sub", oRdValue, 32'h00000007);

    set_op(1'b1, 1'b0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd7);
    tick();
    check("slt", oRdValue, 32'h1);
    set_op(1'b1, 1'b0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd7);
    tick();
    check("sltu", oRdValue, 32'h0);

    iFwS1 = 2'b11; iFwS2 = 2'b10; iFwData = {32'h22, 32'h11};
    set_op(1'b1, 1'b1, 3'd0, 7'h00, 32'h99, 32'h55, 32'h0, 5'd8);
    tick();
    check("fwd_prio", oRdValue, 32'h11);
    check("fwd_store", oStoreData, 32'h22);
    iFwS1 = 2'b00; iFwS2 = 2'b00;

    run_md("mulh", 3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_md("mulhu", 3'd3, 32'hFFFFFFFF, 32'h2, 32'h00000001);
    run_md("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_md("mul", 3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    run_md("div_by0", 3'd4, 32'h7, 32'h0, 32'hFFFFFFFF);
    run_md("rem_by0", 3'd6, 32'h7, 32'h0, 32'h7);
    run_md("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_md("div_neg", 3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
    run_md("rem_neg", 3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);

    // Stall 3 cycles in DONE: state reaches DONE after edge E0+32.
    set_op(1'b1, 1'b0, 3'd5, 7'h01, 32'd100, 32'd7, 32'h0, 5'd12);
    tick();
    iValid = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold_valid", {31'b0, oValid}, 32'h0);
      check("stall_hold_busy", {31'b0, oBusy}, 32'h1);
    end
    iStall = 1'b0;
    tick();
    check("stall_valid", {31'b0, oValid}, 32'h1);
    check("stall_busy", {31'b0, oBusy}, 32'h0);
    check("stall_result", oRdValue, 32'd14);

    // Flush mid-RUN, then a plain ADD must go through.
    set_op(1'b1, 1'b0, 3'd0, 7'h01, 32'd5, 32'd6, 32'h0, 5'd13);
    tick();
    iValid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    check("flush_busy", {31'b0, oBusy}, 32'h0);
    check("flush_valid", {31'b0, oValid}, 32'h0);
    set_op(1'b1, 1'b0, 3'd0, 7'h00, 32'd3, 32'd4, 32'h0, 5'd14);
    tick();
    check("post_flush_valid", {31'b0, oValid}, 32'h1);
    check("post_flush_add", oRdValue, 32'd7);

    // Reset mid-RUN; oRdValue still holds 7 from the ADD until reset hits.
    set_op(1'b1, 1'b0, 3'd4, 7'h01, 32'd50, 32'd3, 32'h0, 5'd15);
    tick();
    iValid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("pre_rst_busy", {31'b0, oBusy}, 32'h1);
    #2 nRst = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, oBusy}, 32'h0);
    check("mid_rst_value", oRdValue, 32'h0);
    check("mid_rst_rd", {27'b0, oRdAddr}, 32'h0);
    #2 nRst = 1'b1;
    tick();
    run_md("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14);
    run_md("remu", 3'd7, 32'd100, 32'd7, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_md_stage.md
# ex_md_stage

Parametrised execute stage that registers its result into the EX/MEM boundary. Three datapaths:
- single-cycle RV integer ALU path;
- iterative radix-2 multiply/divide unit (RV M-extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU);
- N-source operand forwarding, parametrised in width and source count.

Sits between the ID/EX register and the MEM stage. Drives a registered busy flag that the hazard unit uses to hold ID/EX during multi-cycle operations.

## Interface
Parameters
- XLEN, 32: datapath width; must be ≥ 8 and even.
- NFWD, 2: number of forwarding sources; index 0 has highest priority.

Ports
- iClk in 1: clock, rising edge.
- nRst in 1: reset, asynchronous, active-low.
- iStall in 1: downstream stall; output register and acceptance hold.
- iFlush in 1: synchronous squash of the output register and any in-flight mul/div.
- iValid in 1: instruction on inputs is valid.
- iExEn in 1: instruction uses the execute unit; if 0, the ALU performs ADD.
- iImmEn in 1: operand B = iImm.
- iFunc3 in 3: funct3.
- iFunc7 in 7: funct7.
- iRs1 in XLEN: rs1 register-file value.
- iRs2 in XLEN: rs2 register-file value.
- iImm in XLEN: sign-extended immediate.
- iRdAddr in 5: destination register.
- iFwS1 in NFWD: per-source forward enables for rs1.
- iFwS2 in NFWD: per-source forward enables for rs2.
- iFwData in NFWD*XLEN: forward values; source i occupies bits [i*XLEN +: XLEN].
- oValid out 1: output register holds a valid result.
- oRdAddr out 5: destination register.
- oRdValue out XLEN: result.
- oStoreData out XLEN: forwarded rs2 value, for stores.
- oBusy out 1: registered; mul/div in progress, upstream must hold.

## Operation
- **Operand A:** iFwData of the lowest-index set bit in iFwS1, else iRs1.
- **rs2 value (fw2):** same rule using iFwS2, else iRs2.
- **Operand B:** iImm if iImmEn, else fw2. oStoreData always takes fw2.
- **Mul/div select:** is_md = iValid & iExEn & !iImmEn & (iFunc7 == 7'b0000001).
- **ALU:** funct3/funct7 decode per RV32I: ADD/SUB (f7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (f7[5]), OR, AND.
  - Shift amount is B[$clog2(XLEN)-1:0].
  - If !iValid or !iExEn, the ALU computes A+B.
- **FSM states:** IDLE, RUN, DONE. oBusy = (state != IDLE).
- **IDLE:**
  - If !iStall and !is_md: output register loads {iValid, iRdAddr, ALU result, fw2}.
  - If !iStall and is_md: latch operands |A|, |B|, signs, funct3 and rd; load a bubble (oValid=0); set cnt=XLEN-1; go to RUN.
- **RUN:**
  - Each edge performs one iteration: shift-add multiply on magnitudes (2*XLEN product), or restoring division (quotient and remainder).
  - At cnt==0, go to DONE; otherwise decrement cnt.
  - iStall does not pause iteration. The output register holds.
- **DONE:**
  - If !iStall: output register loads {1, rd, md result, 0}; go to IDLE.
  - If iStall: remain in DONE.
- **Sign fix:**
  - Product is negated when operand signs differ (signed operands only). MUL returns low XLEN bits; MULH, MULHSU and MULHU return high XLEN bits.
  - Quotient sign = sa^sb; remainder sign = sa.
- **Divide corner cases:**
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - Both are resolved at DONE. Iterations still run, so latency is constant.
- **iFlush** has priority over iStall: output register cleared, state to IDLE, in-flight op discarded, no input accepted that edge.
- **Upstream contract:** the hazard unit holds ID/EX while oBusy | iStall. The held instruction is accepted on the first edge with state IDLE and !iStall.

## Timing
- **Reset** (async, nRst=0): oValid=0, oRdAddr=0, oRdValue=0, oStoreData=0, oBusy=0, state IDLE, cnt=0, latched operands 0.
- **ALU ops:** 1-cycle latency; result visible after the accepting edge.
- **Mul/div without stall:**
  - Accept at edge E0.
  - oBusy=1 from after E0 through DONE.
  - Result valid after edge E0+XLEN+1.
  - oBusy falls after the same edge.
  - Back-to-back mul/div throughput: one per XLEN+2 cycles.
- **Mul/div with stall:** each cycle of iStall while in DONE adds one cycle.
- **Reset mid-operation:** returns to the reset state immediately; no partial result is emitted.
- **Flush and result same edge:** iFlush in the same cycle as DONE: the result is dropped and oValid=0.
- **Forwarding inputs** are combinational; the path from iFwData to the output register is a single cycle.

## Test plan
- **ALU, immediate:** XLEN=32; A=0x7FFFFFFF; ADDI imm=1 -> oRdValue=0x80000000, oValid=1 after 1 edge. SRA with A=0x80000000, shamt 4 -> 0xF8000000.
- **Forward priority:** iFwS1=2'b11, iFwData={0x22,0x11}, iRs1=0x99, ADD B=0 -> 0x11. Store with iImmEn and iFwS2[1] -> oStoreData=0x22.
- **MUL/MULH:** MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF. MULHU same operands -> 0x00000001.
  - oBusy high for exactly 33 cycles.
  - Result appears after edge E0+33.
- **DIV corners:**
  - DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - DIV -7/2 -> -3; REM -> -1.
- **Stall/flush:** iStall held 3 cycles in DONE -> result delayed 3 cycles, unchanged. iFlush during RUN -> oBusy=0 and oValid=0 next cycle; the next ADD completes normally.
- **Reset mid-RUN:** nRst low -> all outputs 0 asynchronously. After release, a DIVU 100/7 -> 14 with correct latency.
